pong_game_ctrl: RTL

- Top-level game-flow controller for the pong game.
- Sequences new-game, play, new-ball and game-over phases.
- Keeps the 2-digit BCD score and the remaining-lives count.
- Drives the countdown timer (timer_start, timer_tick) and consumes its timer_up flag to pace the new-ball and game-over pauses.
- Outputs feed the graphics stage (gra_still) and the text overlay (text_sel, score digits, lives).

---
 rtl/pong_game_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for pong: sequences new-game / play / new-ball / game-over,
// keeps the 2-digit BCD score and spare-ball count, and paces pauses off the countdown timer.
module pong_game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int LIVES_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn,
    input  logic               hit,
    input  logic               miss,
    input  logic               refresh_tick,
    input  logic               timer_up,
    output logic               timer_start,
    output logic               timer_tick,
    output logic               gra_still,
    output logic [1:0]         text_sel,
    output logic [LIVES_W-1:0] lives,
    output logic [3:0]         dig1,
    output logic [3:0]         dig0
);

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               btn_any_q, btn_any_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [3:0]         dig1_q, dig1_d;
    logic [3:0]         dig0_q, dig0_d;

    logic btn_any;
    logic press;

    assign btn_any = (btn != 2'b00);
    assign press   = btn_any & ~btn_any_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_NEWGAME;
            btn_any_q <= 1'b0;
            lives_q   <= LIVES_W'(LIVES_INIT);
            dig1_q    <= 4'd0;
            dig0_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            btn_any_q <= btn_any_d;
            lives_q   <= lives_d;
            dig1_q    <= dig1_d;
            dig0_q    <= dig0_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NEWGAME: if (press) state_d = ST_PLAY;
            ST_PLAY: begin
                if (miss) begin
                    if (lives_q != '0) state_d = ST_NEWBALL;
                    else               state_d = ST_OVER;
                end
            end
            ST_NEWBALL: if (timer_up && press) state_d = ST_PLAY;
            ST_OVER:    if (timer_up) state_d = ST_NEWGAME;
            default:    state_d = ST_NEWGAME;
        endcase
    end

    // Score and lives; miss takes priority over a simultaneous hit
    always_comb begin
        btn_any_d = btn_any;
        lives_d   = lives_q;
        dig1_d    = dig1_q;
        dig0_d    = dig0_q;
        case (state_q)
            ST_NEWGAME: begin
                if (press) begin
                    lives_d = LIVES_W'(LIVES_INIT);
                    dig1_d  = 4'd0;
                    dig0_d  = 4'd0;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
                end else if (hit) begin
                    if (dig0_q != 4'd9) begin
                        dig0_d = dig0_q + 4'd1;
                    end else if (dig1_q != 4'd9) begin
                        dig0_d = 4'd0;
                        dig1_d = dig1_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Moore outputs plus the pass-through timer controls
    always_comb begin
        gra_still   = 1'b1;
        text_sel    = 2'd1;
        timer_tick  = refresh_tick;
        timer_start = ~reset & miss & (state_q == ST_PLAY);
        case (state_q)
            ST_NEWGAME: begin gra_still = 1'b1; text_sel = 2'd1; end
            ST_PLAY:    begin gra_still = 1'b0; text_sel = 2'd0; end
            ST_NEWBALL: begin gra_still = 1'b1; text_sel = 2'd2; end
            ST_OVER:    begin gra_still = 1'b1; text_sel = 2'd3; end
            default:    begin gra_still = 1'b1; text_sel = 2'd1; end
        endcase
    end

    assign lives = lives_q;
    assign dig1  = dig1_q;
    assign dig0  = dig0_q;

endmodule
